// File: rtl/pipeline_hazard_unit.sv
// Operand forwarding plus load-use / memory-busy / branch hazard control for a
// classic five-stage pipeline, with saturating stall and flush event counters.
module pipeline_hazard_unit #(
    parameter int ADDR_W            = 5,
    parameter int NUM_SRC           = 2,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [NUM_SRC*ADDR_W-1:0] id_ex_src_addr,
    input  logic [ADDR_W-1:0]         id_ex_dest_addr,
    input  logic                      id_ex_mem_read,
    input  logic [ADDR_W-1:0]         ex_mem_dest_addr,
    input  logic                      ex_mem_write_enable,
    input  logic [ADDR_W-1:0]         mem_wb_dest_addr,
    input  logic                      mem_wb_write_enable,
    input  logic                      branch_taken,
    input  logic                      mem_busy,
    output logic [2*NUM_SRC-1:0]      operand_forward,
    output logic                      stall_pc,
    output logic                      stall_if_id,
    output logic                      stall_id_ex,
    output logic                      stall_ex_mem,
    output logic                      flush_if_id,
    output logic                      flush_id_ex,
    output logic [CNT_W-1:0]          stall_cycle_count,
    output logic [CNT_W-1:0]          flush_count
);

    localparam int REM_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic {RUN, LOAD_STALL} state_t;

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             ld_hz;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + CNT_W'(1);
    endfunction

    // EX-stage forwarding: the younger EX/MEM result wins over MEM/WB
    always_comb begin
        operand_forward = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_mem_write_enable && (ex_mem_dest_addr != '0) &&
                (ex_mem_dest_addr == id_ex_src_addr[i*ADDR_W +: ADDR_W]))
                operand_forward[2*i +: 2] = FWD_EX;
            else if (mem_wb_write_enable && (mem_wb_dest_addr != '0) &&
                     (mem_wb_dest_addr == id_ex_src_addr[i*ADDR_W +: ADDR_W]))
                operand_forward[2*i +: 2] = FWD_MEM;
            else
                operand_forward[2*i +: 2] = FWD_NONE;
        end
    end

    always_comb begin
        ld_hz = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && (id_src_addr[i*ADDR_W +: ADDR_W] == id_ex_dest_addr))
                ld_hz = 1'b1;
        end
        ld_hz = ld_hz && id_ex_mem_read && (id_ex_dest_addr != '0);
    end

    // Hazard control: busy freezes everything, a taken branch cancels any bubble
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        if (rst) begin
            state_d = RUN;
            rem_d   = '0;
        end else if (mem_busy) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
        end else if (branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            state_d     = RUN;
            rem_d       = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ld_hz) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LOAD_STALL;
                            rem_d   = REM_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                LOAD_STALL: begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    rem_d       = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1))
                        state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    rem_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= RUN;
            rem_q             <= '0;
            stall_cycle_count <= '0;
            flush_count       <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (stall_pc)
                stall_cycle_count <= sat_inc(stall_cycle_count);
            if (flush_if_id)
                flush_count <= sat_inc(flush_count);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: instance a (3 sources, 3-cycle load stall) and instance b
// (2 sources, 4-cycle load stall, 4-bit counters) share the scalar inputs.
module tb_pipeline_hazard_unit;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_ex_dest_addr, ex_mem_dest_addr, mem_wb_dest_addr;
    logic id_ex_mem_read, ex_mem_write_enable, mem_wb_write_enable, branch_taken, mem_busy;

    logic [14:0] src_a, exsrc_a;
    logic [2:0]  used_a;
    logic [5:0]  fwd_a;
    logic        sp_a, sif_a, sidex_a, sexm_a, fif_a, fidex_a;
    logic [15:0] scnt_a, fcnt_a;

    logic [9:0]  src_b, exsrc_b;
    logic [1:0]  used_b;
    logic [3:0]  fwd_b;
    logic        sp_b, sif_b, sidex_b, sexm_b, fif_b, fidex_b;
    logic [3:0]  scnt_b, fcnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.ADDR_W(5), .NUM_SRC(3), .LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_src_addr(src_a), .id_src_used(used_a),
        .id_ex_src_addr(exsrc_a), .id_ex_dest_addr(id_ex_dest_addr),
        .id_ex_mem_read(id_ex_mem_read), .ex_mem_dest_addr(ex_mem_dest_addr),
        .ex_mem_write_enable(ex_mem_write_enable), .mem_wb_dest_addr(mem_wb_dest_addr),
        .mem_wb_write_enable(mem_wb_write_enable), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .operand_forward(fwd_a), .stall_pc(sp_a),
        .stall_if_id(sif_a), .stall_id_ex(sidex_a), .stall_ex_mem(sexm_a),
        .flush_if_id(fif_a), .flush_id_ex(fidex_a),
        .stall_cycle_count(scnt_a), .flush_count(fcnt_a));

    pipeline_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_STALL_CYCLES(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_src_addr(src_b), .id_src_used(used_b),
        .id_ex_src_addr(exsrc_b), .id_ex_dest_addr(id_ex_dest_addr),
        .id_ex_mem_read(id_ex_mem_read), .ex_mem_dest_addr(ex_mem_dest_addr),
        .ex_mem_write_enable(ex_mem_write_enable), .mem_wb_dest_addr(mem_wb_dest_addr),
        .mem_wb_write_enable(mem_wb_write_enable), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .operand_forward(fwd_b), .stall_pc(sp_b),
        .stall_if_id(sif_b), .stall_id_ex(sidex_b), .stall_ex_mem(sexm_b),
        .flush_if_id(fif_b), .flush_id_ex(fidex_b),
        .stall_cycle_count(scnt_b), .flush_count(fcnt_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_ex_dest_addr = '0; ex_mem_dest_addr = '0; mem_wb_dest_addr = '0;
        id_ex_mem_read = 1'b0; ex_mem_write_enable = 1'b0; mem_wb_write_enable = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0;
        src_a = '0; exsrc_a = '0; used_a = '0;
        src_b = '0; exsrc_b = '0; used_b = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_load_a();
        id_ex_mem_read = 1'b1; id_ex_dest_addr = 5'd4;
        src_a = {5'd0, 5'd0, 5'd4}; used_a = 3'b001;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        set_load_a();
        ex_mem_dest_addr = 5'd5; ex_mem_write_enable = 1'b1; exsrc_a = {5'd0, 5'd0, 5'd5};
        #1;
        total++; if ({sp_a, sif_a, sidex_a, sexm_a, fif_a, fidex_a} !== 6'b0) begin
            bad++; $display("FAIL rst_outputs: got %b expected 000000", {sp_a, sif_a, sidex_a, sexm_a, fif_a, fidex_a}); end
        total++; if (fwd_a !== 6'b00_00_01) begin
            bad++; $display("FAIL rst_forward: got %b expected 000001", fwd_a); end
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        total++; if (scnt_a !== 16'd0 || fcnt_a !== 16'd0) begin
            bad++; $display("FAIL rst_counters: got %0d/%0d expected 0/0", scnt_a, fcnt_a); end
        total++; if (sp_a !== 1'b0) begin
            bad++; $display("FAIL rst_idle_stall: got %b expected 0", sp_a); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        exsrc_a = {5'd7, 5'd6, 5'd5};
        ex_mem_dest_addr = 5'd5; ex_mem_write_enable = 1'b1;
        mem_wb_dest_addr = 5'd7; mem_wb_write_enable = 1'b1;
        #1;
        total++; if (fwd_a !== 6'b10_00_01) begin
            bad++; $display("FAIL fwd_mixed: got %b expected 100001", fwd_a); end
        ex_mem_dest_addr = 5'd7;
        #1;
        total++; if (fwd_a !== 6'b01_00_00) begin
            bad++; $display("FAIL fwd_ex_priority: got %b expected 010000", fwd_a); end
        ex_mem_write_enable = 1'b0;
        #1;
        total++; if (fwd_a !== 6'b10_00_00) begin
            bad++; $display("FAIL fwd_ex_we_off: got %b expected 100000", fwd_a); end
        ex_mem_write_enable = 1'b1;
        exsrc_a = '0; ex_mem_dest_addr = '0; mem_wb_dest_addr = '0;
        #1;
        total++; if (fwd_a !== 6'b0) begin
            bad++; $display("FAIL fwd_zero_addr: got %b expected 000000", fwd_a); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_a();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin tick(); id_ex_mem_read = 1'b0; end
            #1;
            total++; if ({sp_a, sif_a, fidex_a} !== 3'b111) begin
                bad++; $display("FAIL load_stall_c%0d: got %b expected 111", c, {sp_a, sif_a, fidex_a}); end
        end
        tick();
        #1;
        total++; if ({sp_a, sif_a, fidex_a} !== 3'b000) begin
            bad++; $display("FAIL load_stall_end: got %b expected 000", {sp_a, sif_a, fidex_a}); end
        total++; if (scnt_a !== 16'd3) begin
            bad++; $display("FAIL load_stall_count: got %0d expected 3", scnt_a); end
        do_reset();
        set_load_a();
        used_a = 3'b000;
        #1;
        total++; if (sp_a !== 1'b0) begin
            bad++; $display("FAIL load_unused_src: got %b expected 0", sp_a); end
        tick();
        #1;
        total++; if (sp_a !== 1'b0 || scnt_a !== 16'd0) begin
            bad++; $display("FAIL load_unused_after: got %b/%0d expected 0/0", sp_a, scnt_a); end
    endtask

    task automatic test_mem_busy();
        logic [5:0] busy_v  = 6'b000110;
        logic [5:0] stall_v = 6'b011111;
        logic [5:0] fl_v    = 6'b011001;
        do_reset();
        set_load_a();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin tick(); id_ex_mem_read = 1'b0; end
            mem_busy = busy_v[c];
            #1;
            total++; if ({sp_a, sif_a, sidex_a, sexm_a, fidex_a} !== {stall_v[c], stall_v[c], busy_v[c], busy_v[c], fl_v[c]}) begin
                bad++; $display("FAIL busy_c%0d: got %b expected %b", c, {sp_a, sif_a, sidex_a, sexm_a, fidex_a},
                                {stall_v[c], stall_v[c], busy_v[c], busy_v[c], fl_v[c]}); end
        end
        total++; if (scnt_a !== 16'd5) begin
            bad++; $display("FAIL busy_count: got %0d expected 5", scnt_a); end
    endtask

    task automatic test_branch();
        do_reset();
        set_load_a();
        branch_taken = 1'b1;
        #1;
        total++; if ({fif_a, fidex_a, sp_a, sif_a} !== 4'b1100) begin
            bad++; $display("FAIL branch_vs_load: got %b expected 1100", {fif_a, fidex_a, sp_a, sif_a}); end
        tick();
        branch_taken = 1'b0; id_ex_mem_read = 1'b0;
        #1;
        total++; if (sp_a !== 1'b0 || fcnt_a !== 16'd1) begin
            bad++; $display("FAIL branch_after: got %b/%0d expected 0/1", sp_a, fcnt_a); end
        set_load_a();
        #1;
        total++; if (sp_a !== 1'b1) begin
            bad++; $display("FAIL branch_load_start: got %b expected 1", sp_a); end
        tick();
        id_ex_mem_read = 1'b0; branch_taken = 1'b1;
        #1;
        total++; if ({fif_a, fidex_a, sp_a} !== 3'b110) begin
            bad++; $display("FAIL branch_in_stall: got %b expected 110", {fif_a, fidex_a, sp_a}); end
        tick();
        branch_taken = 1'b0;
        #1;
        total++; if (sp_a !== 1'b0 || fidex_a !== 1'b0) begin
            bad++; $display("FAIL branch_abort: got %b%b expected 00", sp_a, fidex_a); end
        total++; if (fcnt_a !== 16'd2 || scnt_a !== 16'd1) begin
            bad++; $display("FAIL branch_counts: got %0d/%0d expected 2/1", fcnt_a, scnt_a); end
    endtask

    task automatic test_reset_in_stall();
        do_reset();
        id_ex_mem_read = 1'b1; id_ex_dest_addr = 5'd4;
        src_b = {5'd0, 5'd4}; used_b = 2'b01;
        #1;
        total++; if (sp_b !== 1'b1) begin
            bad++; $display("FAIL rstst_start: got %b expected 1", sp_b); end
        tick();
        id_ex_mem_read = 1'b0; rst = 1'b1;
        #1;
        total++; if ({sp_b, sif_b, fidex_b} !== 3'b000) begin
            bad++; $display("FAIL rstst_during: got %b expected 000", {sp_b, sif_b, fidex_b}); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (sp_b !== 1'b0 || scnt_b !== 4'd0 || fcnt_b !== 4'd0) begin
            bad++; $display("FAIL rstst_after: got %b/%0d/%0d expected 0/0/0", sp_b, scnt_b, fcnt_b); end
        tick();
        #1;
        total++; if (sp_b !== 1'b0 || fidex_b !== 1'b0) begin
            bad++; $display("FAIL rstst_residual: got %b%b expected 00", sp_b, fidex_b); end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_busy = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (n == 14) begin
                total++; if (scnt_b !== 4'd14) begin
                    bad++; $display("FAIL sat_count14: got %0d expected 14", scnt_b); end
            end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        total++; if (scnt_b !== 4'd15) begin
            bad++; $display("FAIL sat_hold: got %0d expected 15", scnt_b); end
        total++; if (scnt_a !== 16'd20) begin
            bad++; $display("FAIL sat_wide_count: got %0d expected 20", scnt_a); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_busy();
        test_branch();
        test_reset_in_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
